// File: rtl/rv_pkg.sv
// rv_pkg
//   Shared definitions for the stream demultiplexer slice.
//   XLEN     : default datapath width (32)
//   SEL_OUT0 : in_sel encoding that steers a beat to out0
//   SEL_OUT1 : in_sel encoding that steers a beat to out1
package rv_pkg;
   localparam int   XLEN     = 32;
   localparam logic SEL_OUT0 = 1'b0;
   localparam logic SEL_OUT1 = 1'b1;
endpackage

// File: rtl/stream_demux2_if.sv
// stream_demux2_if
//   Bundles the producer stream, both consumer streams and the per-output
//   beat counters of stream_demux2.
//   master : producer/consumer side (drives in_*, outk_ready)
//   slave  : demux side (drives in_ready, outk_data/valid, cntk)
interface stream_demux2_if
   import rv_pkg::*;
#(
   parameter int WIDTH = XLEN,
   parameter int CNT_W = 16
) ();
   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out0_data;
   logic             out0_valid;
   logic             out0_ready;
   logic [WIDTH-1:0] out1_data;
   logic             out1_valid;
   logic             out1_ready;
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;

   modport master (
      output in_data, in_sel, in_valid, out0_ready, out1_ready,
      input  in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
   );

   modport slave (
      input  in_data, in_sel, in_valid, out0_ready, out1_ready,
      output in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
   );
endinterface

// File: rtl/stream_demux2_fifo2.sv
// fifo2
//   Two-entry synchronous queue with registered storage.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (ignored while full)
//   push_data  : beat to enqueue
//   pop        : drop the head beat (ignored while empty)
//   head_data  : beat at the head of the queue
//   empty/full : occupancy flags (count == 0 / count == 2)
module fifo2
   import rv_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic             full
);
   logic [WIDTH-1:0] mem_reg [2];
   logic             wr_ptr_reg;
   logic             rd_ptr_reg;
   logic [1:0]       count_reg;
   logic             push_ok;
   logic             pop_ok;

   assign empty = (count_reg == 2'd0);
   assign full  = (count_reg == 2'd2);

   // Self-protect against overflow/underflow even if the caller misbehaves.
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   assign head_data = mem_reg[rd_ptr_reg];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_reg[0] <= '0;
         mem_reg[1] <= '0;
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data;
            wr_ptr_reg          <= ~wr_ptr_reg;
         end
         if (pop_ok) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         // Simultaneous push and pop leaves the occupancy unchanged.
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end
endmodule

// File: rtl/stream_demux2.sv
// stream_demux2
//   1:2 stream demultiplexer. Each producer beat is steered by in_sel to one
//   of two 2-entry queues; each output drains independently, so a stalled
//   consumer only blocks beats addressed to it.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : stream_demux2_if slave port (producer stream, two consumer
//                streams, per-output delivered-beat counters cnt0/cnt1)
module stream_demux2
   import rv_pkg::*;
#(
   parameter int WIDTH = XLEN,
   parameter int CNT_W = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   stream_demux2_if.slave bus
);
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_out
         localparam logic SEL_CODE = (gi == 0) ? SEL_OUT0 : SEL_OUT1;

         logic             rdy;
         logic             push;
         logic             pop;
         logic             empty;
         logic             full;
         logic [WIDTH-1:0] head;
         logic [CNT_W-1:0] cnt_reg;

         assign rdy  = (gi == 0) ? bus.out0_ready : bus.out1_ready;
         // A push only happens on a real input transfer to this queue.
         assign push = bus.in_valid & (bus.in_sel == SEL_CODE) & ~full;
         assign pop  = rdy & ~empty;

         fifo2 #(
            .WIDTH(WIDTH)
         ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push),
            .push_data (bus.in_data),
            .pop       (pop),
            .head_data (head),
            .empty     (empty),
            .full      (full)
         );

         // Counts completed output transfers; wraps naturally.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_reg <= '0;
            end else if (pop) begin
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
         end
      end
   endgenerate

   // Ready depends only on the selected queue's occupancy, never on the
   // consumer readies, so there is no ready->ready combinational path.
   assign bus.in_ready   = (bus.in_sel == SEL_OUT1) ? ~g_out[1].full : ~g_out[0].full;

   assign bus.out0_data  = g_out[0].head;
   assign bus.out0_valid = ~g_out[0].empty;
   assign bus.cnt0       = g_out[0].cnt_reg;
   assign bus.out1_data  = g_out[1].head;
   assign bus.out1_valid = ~g_out[1].empty;
   assign bus.cnt1       = g_out[1].cnt_reg;
endmodule

// File: tb/tb_stream_demux2.sv
// tb_stream_demux2
//   Directed self-checking bench for stream_demux2 (CNT_W = 4 so the
//   counter wrap is reachable quickly).
module tb_stream_demux2;
   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   stream_demux2_if #(.WIDTH(32), .CNT_W(4)) bus ();

   stream_demux2 #(
      .WIDTH(32),
      .CNT_W(4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("vec %0d %s obs=%h exp=%h", vectors, tag, obs, exp);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic [31:0] d);
      bus.in_valid = v;
      bus.in_sel   = s;
      bus.in_data  = d;
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      bus.out0_ready = 1'b1;
      bus.out1_ready = 1'b1;

      // ---------------- reset check ----------------
      rst_n = 1'b0;
      drive(1'b1, 1'b1, 32'hdeadbeef);
      #1;
      chk("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
      chk("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
      chk("rst_out0_data", bus.out0_data, 32'd0);
      chk("rst_out1_data", bus.out1_data, 32'd0);
      chk("rst_cnt0", 32'(bus.cnt0), 32'd0);
      chk("rst_cnt1", 32'(bus.cnt1), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      tick();
      chk("rst_hold_out1_valid", 32'(bus.out1_valid), 32'd0);
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("post_rst_out0_valid", 32'(bus.out0_valid), 32'd0);
      chk("post_rst_out1_valid", 32'(bus.out1_valid), 32'd0);
      chk("post_rst_cnt1", 32'(bus.cnt1), 32'd0);

      // ---------------- basic steering ----------------
      drive(1'b1, 1'b1, 32'h0000ffff);
      #1;
      chk("basic1_in_ready", 32'(bus.in_ready), 32'd1);
      chk("basic1_no_comb_path", 32'(bus.out1_valid), 32'd0);
      tick();
      bus.in_valid = 1'b0;
      chk("basic1_out1_valid", 32'(bus.out1_valid), 32'd1);
      chk("basic1_out1_data", bus.out1_data, 32'h0000ffff);
      chk("basic1_out0_valid", 32'(bus.out0_valid), 32'd0);
      tick();
      chk("basic1_cnt1", 32'(bus.cnt1), 32'd1);
      chk("basic1_drained", 32'(bus.out1_valid), 32'd0);

      drive(1'b1, 1'b0, 32'haaaa0000);
      tick();
      bus.in_valid = 1'b0;
      chk("basic0_out0_valid", 32'(bus.out0_valid), 32'd1);
      chk("basic0_out0_data", bus.out0_data, 32'haaaa0000);
      chk("basic0_out1_valid", 32'(bus.out1_valid), 32'd0);
      tick();
      chk("basic0_cnt0", 32'(bus.cnt0), 32'd1);
      chk("basic0_cnt1_kept", 32'(bus.cnt1), 32'd1);

      // ---------------- backpressure isolation ----------------
      do_reset();
      bus.out0_ready = 1'b0;
      bus.out1_ready = 1'b1;
      drive(1'b1, 1'b0, 32'd1);
      #1;
      chk("bp_beat1_ready", 32'(bus.in_ready), 32'd1);
      tick();
      drive(1'b1, 1'b0, 32'd2);
      #1;
      chk("bp_beat2_ready", 32'(bus.in_ready), 32'd1);
      tick();
      drive(1'b1, 1'b0, 32'd3);
      #1;
      chk("bp_beat3_refused", 32'(bus.in_ready), 32'd0);
      chk("bp_head_1", bus.out0_data, 32'd1);
      drive(1'b1, 1'b1, 32'd5);
      #1;
      chk("bp_sel1_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      chk("bp_out1_valid", 32'(bus.out1_valid), 32'd1);
      chk("bp_out1_data", bus.out1_data, 32'd5);
      chk("bp_stable_head", bus.out0_data, 32'd1);
      tick();
      chk("bp_cnt1", 32'(bus.cnt1), 32'd1);
      chk("bp_cnt0_stalled", 32'(bus.cnt0), 32'd0);
      // Release the consumer and retry the refused beat 3.
      bus.out0_ready = 1'b1;
      drive(1'b1, 1'b0, 32'd3);
      #1;
      chk("bp_full_ignores_out_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_deliver_1", bus.out0_data, 32'd1);
      tick();
      chk("bp_deliver_2", bus.out0_data, 32'd2);
      chk("bp_retry_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      chk("bp_deliver_3", bus.out0_data, 32'd3);
      chk("bp_valid_3", 32'(bus.out0_valid), 32'd1);
      tick();
      chk("bp_cnt0", 32'(bus.cnt0), 32'd3);
      chk("bp_drained", 32'(bus.out0_valid), 32'd0);

      // ---------------- simultaneous push/pop at count 1 ----------------
      do_reset();
      bus.out0_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b0, 32'(10 + i));
         #1;
         chk("pp_in_ready", 32'(bus.in_ready), 32'd1);
         tick();
         chk("pp_head", bus.out0_data, 32'(10 + i));
         chk("pp_valid", 32'(bus.out0_valid), 32'd1);
      end
      bus.in_valid = 1'b0;
      tick();
      chk("pp_cnt0", 32'(bus.cnt0), 32'd10);
      chk("pp_drained", 32'(bus.out0_valid), 32'd0);

      // ---------------- counter wrap (CNT_W = 4) ----------------
      do_reset();
      bus.out1_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 1'b1, 32'(100 + i));
         tick();
      end
      bus.in_valid = 1'b0;
      chk("wrap_cnt1_at_16", 32'(bus.cnt1), 32'd0);
      chk("wrap_last_head", bus.out1_data, 32'd116);
      tick();
      chk("wrap_cnt1", 32'(bus.cnt1), 32'd1);

      // ---------------- mid-stream reset ----------------
      do_reset();
      bus.out0_ready = 1'b0;
      bus.out1_ready = 1'b0;
      drive(1'b1, 1'b0, 32'h000000a1);
      tick();
      drive(1'b1, 1'b0, 32'h000000a2);
      tick();
      drive(1'b1, 1'b1, 32'h000000b1);
      tick();
      drive(1'b1, 1'b1, 32'h000000b2);
      tick();
      drive(1'b1, 1'b0, 32'h000000a3);
      #1;
      chk("mid_q0_full", 32'(bus.in_ready), 32'd0);
      bus.in_sel = 1'b1;
      #1;
      chk("mid_q1_full", 32'(bus.in_ready), 32'd0);
      bus.in_valid   = 1'b0;
      bus.out0_ready = 1'b1;
      bus.out1_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("mid_out0_valid", 32'(bus.out0_valid), 32'd0);
      chk("mid_out1_valid", 32'(bus.out1_valid), 32'd0);
      chk("mid_out0_data", bus.out0_data, 32'd0);
      chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
      #4;
      rst_n = 1'b1;
      tick();
      drive(1'b1, 1'b0, 32'h00000077);
      tick();
      bus.in_valid = 1'b0;
      chk("mid_post_data", bus.out0_data, 32'h00000077);
      chk("mid_post_valid", 32'(bus.out0_valid), 32'd1);
      chk("mid_no_stale_out1", 32'(bus.out1_valid), 32'd0);
      tick();
      chk("mid_post_cnt0", 32'(bus.cnt0), 32'd1);
      chk("mid_post_cnt1", 32'(bus.cnt1), 32'd0);
      chk("mid_post_drained", 32'(bus.out0_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
